// File: rtl/roll_history.sv
// roll_history: circular history of final roll results with prev/next browsing.
// Each captured result is stored in a DEPTH-entry ring. The user can step back
// through older results and return to the live (newest) view. All outputs are
// registered, so every input event shows up exactly one cycle after it is sampled.
// Optional build macro HIST_WRAP_EN: browsing wraps around between offset 1 and
// the oldest entry, and only i_live or i_capture leave the browse view.
module roll_history #(
    parameter int DEPTH = 8,
    parameter int DW    = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_capture,
    input  logic [DW-1:0]            i_value,
    input  logic                     i_prev,
    input  logic                     i_next,
    input  logic                     i_live,
    output logic [DW-1:0]            o_display,
    output logic [$clog2(DEPTH)-1:0] o_offset,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_browsing
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {S_LIVE = 1'b0, S_BROWSE = 1'b1} state_t;

    state_t          state_q,  state_d;
    logic [AW-1:0]   offset_q, offset_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q,  count_d;
    logic [DW-1:0]   display_q, display_d;
    logic [DW-1:0]   mem_q [DEPTH];
    logic [DW-1:0]   mem_d [DEPTH];
    logic [AW-1:0]   rd_addr;

    // Next-state logic: capture beats live, live beats browse keys, and
    // prev+next together cancel out.
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (i_capture) begin
            mem_d[wr_ptr_q] = i_value;
            wr_ptr_d        = wr_ptr_q + AW'(1);
            if (count_q != FULL) begin
                count_d = count_q + (AW+1)'(1);
            end
            state_d  = S_LIVE;
            offset_d = '0;
        end else if (i_live) begin
            state_d  = S_LIVE;
            offset_d = '0;
        end else if (i_prev && i_next) begin
            // Conflicting keys: hold everything.
        end else if (i_prev) begin
            if (state_q == S_LIVE) begin
                // Browsing needs at least one entry older than the newest.
                if (count_q >= (AW+1)'(2)) begin
                    state_d  = S_BROWSE;
                    offset_d = AW'(1);
                end
            end else if ({1'b0, offset_q} < count_q - (AW+1)'(1)) begin
                offset_d = offset_q + AW'(1);
            end else begin
`ifdef HIST_WRAP_EN
                offset_d = AW'(1);
`else
                offset_d = offset_q;
`endif
            end
        end else if (i_next) begin
            if (state_q == S_BROWSE) begin
                if (offset_q > AW'(1)) begin
                    offset_d = offset_q - AW'(1);
                end else begin
`ifdef HIST_WRAP_EN
                    offset_d = AW'(count_q - (AW+1)'(1));
`else
                    state_d  = S_LIVE;
                    offset_d = '0;
`endif
                end
            end
        end
    end

    // Display source: the just-captured value is forwarded directly so the
    // display never shows the entry that was in the slot before the write.
    always_comb begin
        rd_addr = wr_ptr_d - AW'(1) - offset_d;
        if (i_capture) begin
            display_d = i_value;
        end else if (count_d == '0) begin
            display_d = '0;
        end else begin
            display_d = mem_q[rd_addr];
        end
    end

    // State, pointer, counters and history storage; reset clears the ring too.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_LIVE;
            offset_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            display_q <= '0;
            mem_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            display_q <= display_d;
            mem_q     <= mem_d;
        end
    end

    assign o_display  = display_q;
    assign o_offset   = offset_q;
    assign o_count    = count_q;
    assign o_browsing = (state_q == S_BROWSE);

endmodule

// File: tb/tb_roll_history.sv
// tb_roll_history: directed vectors for roll_history (DEPTH=8, DW=4, default build).
module tb_roll_history;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_capture;
    logic [3:0] i_value;
    logic       i_prev;
    logic       i_next;
    logic       i_live;
    logic [3:0] o_display;
    logic [2:0] o_offset;
    logic [3:0] o_count;
    logic       o_browsing;

    int n_vec;
    int n_bad;

    roll_history #(.DEPTH(8), .DW(4)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_capture  (i_capture),
        .i_value    (i_value),
        .i_prev     (i_prev),
        .i_next     (i_next),
        .i_live     (i_live),
        .o_display  (o_display),
        .o_offset   (o_offset),
        .o_count    (o_count),
        .o_browsing (o_browsing)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic chk_all(input string tag, input int disp, input int off,
                           input int cnt, input int br);
        chk({tag, ".display"},  int'(o_display),  disp);
        chk({tag, ".offset"},   int'(o_offset),   off);
        chk({tag, ".count"},    int'(o_count),    cnt);
        chk({tag, ".browsing"}, int'(o_browsing), br);
    endtask

    // One clock with the given inputs held; afterwards inputs return idle and
    // outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic cap, input logic [3:0] val, input logic p,
                       input logic n, input logic l);
        i_capture = cap; i_value = val; i_prev = p; i_next = n; i_live = l;
        @(posedge i_clk);
        #1;
        i_capture = 1'b0; i_prev = 1'b0; i_next = 1'b0; i_live = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        i_rst_n = 1'b0; i_capture = 1'b0; i_value = '0;
        i_prev = 1'b0; i_next = 1'b0; i_live = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk_all("reset", 0, 0, 0, 0);
        i_rst_n = 1'b1;

        // Keys with an empty history do nothing.
        cyc(0, 0, 1, 0, 0); chk_all("empty_prev", 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0); chk_all("empty_next", 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1); chk_all("empty_live", 0, 0, 0, 0);

        // Capture 3,7,9; each new value shows up the cycle after capture.
        cyc(1, 3, 0, 0, 0); chk_all("cap3", 3, 0, 1, 0);
        cyc(0, 0, 1, 0, 0); chk_all("prev_one_entry", 3, 0, 1, 0);
        cyc(1, 7, 0, 0, 0); chk_all("cap7", 7, 0, 2, 0);
        cyc(1, 9, 0, 0, 0); chk_all("cap9", 9, 0, 3, 0);

        // Browse back; saturate at the oldest entry.
        cyc(0, 0, 1, 0, 0); chk_all("prev1", 7, 1, 3, 1);
        cyc(0, 0, 1, 0, 0); chk_all("prev2", 3, 2, 3, 1);
        cyc(0, 0, 1, 0, 0); chk_all("prev_sat", 3, 2, 3, 1);

        // Capture wins over a simultaneous prev.
        cyc(1, 5, 1, 0, 0); chk_all("cap_over_prev", 5, 0, 4, 0);

        // Next at offset 1 returns to live.
        cyc(0, 0, 1, 0, 0); chk_all("prev_b", 9, 1, 4, 1);
        cyc(0, 0, 0, 1, 0); chk_all("next_to_live", 5, 0, 4, 0);

        // prev+next together is ignored; live leaves browse.
        cyc(0, 0, 1, 0, 0); chk_all("prev_c", 9, 1, 4, 1);
        cyc(0, 0, 1, 1, 0); chk_all("both_keys", 9, 1, 4, 1);
        cyc(0, 0, 1, 0, 1); chk_all("live_over_prev", 5, 0, 4, 0);

        // Asynchronous reset mid-browse clears outputs before the next edge.
        cyc(0, 0, 1, 0, 0); chk_all("prev_d", 9, 1, 4, 1);
        #1 i_rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        chk_all("post_rst", 0, 0, 0, 0);

        // Ten captures into eight slots: 0 and 1 are overwritten.
        for (int v = 0; v < 10; v++) cyc(1, 4'(v), 0, 0, 0);
        chk_all("fill10", 9, 0, 8, 0);
        for (int k = 0; k < 7; k++) cyc(0, 0, 1, 0, 0);
        chk_all("oldest", 2, 7, 8, 1);
        cyc(0, 0, 1, 0, 0); chk_all("oldest_sat", 2, 7, 8, 1);
        cyc(0, 0, 0, 1, 0); chk_all("next_from_oldest", 3, 6, 8, 1);

        // Held key acts as repeated steps.
        i_next = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 i_next = 1'b0;
        chk_all("held_next", 5, 4, 8, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
